// File: rtl/wb_audio_pkg.sv
// Shared constants for the Wishbone audio sample FIFO.
//   reg_idx_e       : register word index decoded from adr_i[3:2]
//   STAT_* / CTRL_* : bit positions inside STATUS and CTRL
//   *_RST           : register reset values
`timescale 1ns/1ps
package wb_audio_pkg;

    typedef enum logic [1:0] {
        REG_DATA   = 2'd0,
        REG_STATUS = 2'd1,
        REG_CTRL   = 2'd2,
        REG_THRESH = 2'd3
    } reg_idx_e;

    localparam int STAT_EMPTY_BIT = 0;
    localparam int STAT_FULL_BIT  = 1;
    localparam int STAT_OVF_BIT   = 2;
    localparam int STAT_LEVEL_LSB = 8;

    localparam int CTRL_EN_BIT  = 0;
    localparam int CTRL_CLR_BIT = 1;

    localparam logic       CTRL_EN_RST = 1'b0;
    localparam logic       OVF_RST     = 1'b0;
    localparam logic [7:0] THRESH_RST  = 8'h00;

endpackage

// File: rtl/wb_sample_fifo_if.sv
// Wishbone B3 slave signal bundle for wb_sample_fifo.
//   slave  modport : used by the FIFO (inputs cyc/stb/we/adr/dat_i/sel, outputs dat_o/ack/err/rty)
//   master modport : used by whoever drives the bus
`timescale 1ns/1ps
interface wb_sample_fifo_if #(
    parameter  int DAT_WIDTH = 32,
    localparam int SEL_WIDTH = DAT_WIDTH / 8
);
    logic                 cyc_i;
    logic                 stb_i;
    logic                 we_i;
    logic [3:0]           adr_i;
    logic [DAT_WIDTH-1:0] dat_i;
    logic [SEL_WIDTH-1:0] sel_i;
    logic [DAT_WIDTH-1:0] dat_o;
    logic                 ack_o;
    logic                 err_o;
    logic                 rty_o;

    modport slave (
        input  cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        output dat_o, ack_o, err_o, rty_o
    );

    modport master (
        output cyc_i, stb_i, we_i, adr_i, dat_i, sel_i,
        input  dat_o, ack_o, err_o, rty_o
    );
endinterface

// File: rtl/wb_sample_fifo_sync_fifo.sv
// sync_fifo: single-clock circular buffer holding audio samples.
//   clk, rst_n       : clock, async active-low reset (pointers/level only)
//   push, push_data  : write one entry; caller guarantees not full (or popping)
//   pop, pop_data    : pop_data always shows the head entry; pop advances it
//   clear            : empties the buffer; caller suppresses push while clearing
//   level/full/empty : occupancy, 0..DEPTH
`timescale 1ns/1ps
module sync_fifo #(
    parameter  int DEPTH = 16,
    parameter  int WIDTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             clear,
    output logic [WIDTH-1:0] pop_data,
    output logic [LW-1:0]    level,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;

    // Storage has no reset; only the bookkeeping is cleared.
    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            // Pointers wrap naturally because DEPTH is a power of two.
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
        end
    end

    assign pop_data = mem[rd_ptr];
    assign full     = (level == LW'(DEPTH));
    assign empty    = (level == '0);

endmodule

// File: rtl/wb_sample_fifo.sv
// wb_sample_fifo: audio sample FIFO with a Wishbone B3 register slave.
//   clk_i        : bus and sample clock
//   rst_i        : async active-low reset; release is synchronised internally
//   smp_valid_i  : unstallable sample strobe, smp_data_i qualified by it
//   wb           : Wishbone slave (DATA/STATUS/CTRL/THRESH at adr_i[3:2])
//   irq_o        : registered level-threshold interrupt
`timescale 1ns/1ps
module wb_sample_fifo
    import wb_audio_pkg::*;
#(
    parameter int DEPTH     = 16,
    parameter int SMP_WIDTH = 16,
    parameter int DAT_WIDTH = 32
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 smp_valid_i,
    input  logic [SMP_WIDTH-1:0] smp_data_i,
    wb_sample_fifo_if.slave      wb,
    output logic                 irq_o
);

    localparam int LW = $clog2(DEPTH) + 1;

    logic                 rst_n;
    reg_idx_e             idx;
    logic                 ack_q;
    logic                 err_q;
    logic                 irq_q;
    logic [DAT_WIDTH-1:0] dat_q;
    logic [DAT_WIDTH-1:0] rd_data;
    logic                 ctrl_en;
    logic [7:0]           thresh;
    logic                 ovf;

    logic                 req;
    logic                 acc_err;
    logic                 acc_ok;
    logic                 wr_ok;
    logic                 lane0;
    logic                 fifo_push;
    logic                 fifo_pop;
    logic                 fifo_clear;
    logic                 smp_in;
    logic                 ovf_set;
    logic                 ovf_clr;

    logic [SMP_WIDTH-1:0] fifo_dout;
    logic [LW-1:0]        fifo_level;
    logic                 fifo_full;
    logic                 fifo_empty;

    // Assert asynchronously, release on the first clock edge so that the
    // second edge after release is the first functional one.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            rst_n <= 1'b0;
        end else begin
            rst_n <= 1'b1;
        end
    end

    assign idx   = reg_idx_e'(wb.adr_i[3:2]);
    assign lane0 = wb.sel_i[0];

    // An access is decided entirely on the edge where it is first seen, so a
    // cycle dropped before that edge never pops or terminates.
    assign req     = wb.cyc_i & wb.stb_i & ~ack_q & ~err_q;
    assign acc_err = req & (idx == REG_DATA) & (wb.we_i | fifo_empty);
    assign acc_ok  = req & ~acc_err;
    assign wr_ok   = acc_ok & wb.we_i;

    assign fifo_pop   = acc_ok & ~wb.we_i & (idx == REG_DATA);
    assign fifo_clear = wr_ok & (idx == REG_CTRL) & lane0 & wb.dat_i[CTRL_CLR_BIT];

    // A pop in the same cycle frees the slot, so a full FIFO still accepts.
    assign smp_in    = ctrl_en & smp_valid_i;
    assign fifo_push = smp_in & (~fifo_full | fifo_pop) & ~fifo_clear;
    assign ovf_set   = smp_in & fifo_full & ~fifo_pop & ~fifo_clear;
    assign ovf_clr   = wr_ok & (idx == REG_STATUS) & lane0 & wb.dat_i[STAT_OVF_BIT];

    sync_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (SMP_WIDTH)
    ) u_fifo (
        .clk       (clk_i),
        .rst_n     (rst_n),
        .push      (fifo_push),
        .push_data (smp_data_i),
        .pop       (fifo_pop),
        .clear     (fifo_clear),
        .pop_data  (fifo_dout),
        .level     (fifo_level),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    always_comb begin
        rd_data = '0;
        case (idx)
            REG_DATA: begin
                rd_data[SMP_WIDTH-1:0] = fifo_dout;
            end
            REG_STATUS: begin
                rd_data[STAT_LEVEL_LSB +: LW] = fifo_level;
                rd_data[STAT_OVF_BIT]         = ovf;
                rd_data[STAT_FULL_BIT]        = fifo_full;
                rd_data[STAT_EMPTY_BIT]       = fifo_empty;
            end
            REG_CTRL: begin
                rd_data[CTRL_EN_BIT] = ctrl_en;
            end
            REG_THRESH: begin
                rd_data[7:0] = thresh;
            end
            default: begin
                rd_data = '0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
            ctrl_en <= CTRL_EN_RST;
            thresh  <= THRESH_RST;
            ovf     <= OVF_RST;
            irq_q   <= 1'b0;
        end else begin
            ack_q <= acc_ok;
            err_q <= acc_err;
            if (acc_ok) begin
                dat_q <= wb.we_i ? '0 : rd_data;
            end
            if (wr_ok && (idx == REG_CTRL) && lane0) begin
                ctrl_en <= wb.dat_i[CTRL_EN_BIT];
            end
            if (wr_ok && (idx == REG_THRESH) && lane0) begin
                thresh <= wb.dat_i[7:0];
            end
            // A new overflow event wins over a simultaneous clear request.
            if (ovf_set) begin
                ovf <= 1'b1;
            end else if (ovf_clr) begin
                ovf <= 1'b0;
            end
            irq_q <= ctrl_en & (int'(fifo_level) >= int'(thresh)) & (thresh != 8'h00);
        end
    end

    assign wb.ack_o = ack_q;
    assign wb.err_o = err_q;
    assign wb.rty_o = 1'b0;
    assign wb.dat_o = dat_q;
    assign irq_o    = irq_q;

    logic unused_bits;
    assign unused_bits = ^{wb.adr_i[1:0], wb.dat_i, wb.sel_i};

endmodule

// File: tb/tb_wb_sample_fifo.sv
`timescale 1ns/1ps
module tb_wb_sample_fifo;
    import wb_audio_pkg::*;

    localparam int DEPTH = 16;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b0;
    logic        smp_valid_i = 1'b0;
    logic [15:0] smp_data_i = '0;
    logic        irq_o;

    always #5 clk_i = ~clk_i;

    wb_sample_fifo_if #(.DAT_WIDTH(32)) wb();

    wb_sample_fifo #(
        .DEPTH     (DEPTH),
        .SMP_WIDTH (16),
        .DAT_WIDTH (32)
    ) dut (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .smp_valid_i (smp_valid_i),
        .smp_data_i  (smp_data_i),
        .wb          (wb),
        .irq_o       (irq_o)
    );

    int          checks = 0;
    int          failures = 0;
    logic [15:0] sb[$];
    logic        ovf_m = 1'b0;
    logic        en_m = 1'b0;
    logic [31:0] rdat;
    logic        tack;
    logic        terr;
    logic        tack2;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] status_exp();
        logic [31:0] s;
        int          l;
        l = sb.size();
        s = '0;
        s[15:8] = 8'(l);
        s[2]    = ovf_m;
        s[1]    = (l == DEPTH);
        s[0]    = (l == 0);
        return s;
    endfunction

    // One bus access; optional simultaneous sample strobe; optional stb hold
    // for one extra cycle to observe the termination dropping.
    task automatic xfer(input logic [3:0] adr, input logic we, input logic [31:0] wd,
                        input logic [3:0] sel, input logic sv, input logic [15:0] sd,
                        input logic hold);
        int n;
        @(negedge clk_i);
        n = 0;
        while ((wb.ack_o || wb.err_o) && n < 4) begin
            @(negedge clk_i);
            n++;
        end
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = we;
        wb.adr_i = adr;
        wb.dat_i = wd;
        wb.sel_i = sel;
        smp_valid_i = sv;
        smp_data_i  = sd;
        tack = 1'b0;
        terr = 1'b0;
        tack2 = 1'b0;
        rdat = 'x;
        for (int i = 0; i < 4; i++) begin
            @(posedge clk_i);
            #1;
            smp_valid_i = 1'b0;
            if (wb.ack_o || wb.err_o) begin
                tack = wb.ack_o;
                terr = wb.err_o;
                rdat = wb.dat_o;
                break;
            end
        end
        if (hold && (tack || terr)) begin
            @(posedge clk_i);
            #1;
            tack2 = wb.ack_o | wb.err_o;
        end
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
    endtask

    task automatic rd_reg(input reg_idx_e r, input logic [31:0] exp, input string tag);
        xfer({r, 2'b00}, 1'b0, 32'h0, 4'hf, 1'b0, 16'h0, 1'b0);
        chk({tag, "_ack"}, {31'b0, tack}, 32'd1);
        chk(tag, rdat, exp);
    endtask

    task automatic wr_reg(input reg_idx_e r, input logic [31:0] d, input logic [3:0] sel, input string tag);
        xfer({r, 2'b00}, 1'b1, d, sel, 1'b0, 16'h0, 1'b0);
        chk({tag, "_ack"}, {31'b0, tack}, 32'd1);
    endtask

    task automatic rd_pop(input string tag, input logic hold);
        logic [15:0] e;
        e = sb.pop_front();
        xfer({REG_DATA, 2'b00}, 1'b0, 32'h0, 4'hf, 1'b0, 16'h0, hold);
        chk({tag, "_ack"}, {31'b0, tack}, 32'd1);
        chk(tag, rdat, {16'h0, e});
        if (hold) chk({tag, "_single"}, {31'b0, tack2}, 32'd0);
    endtask

    task automatic push(input logic [15:0] d);
        @(negedge clk_i);
        smp_valid_i = 1'b1;
        smp_data_i  = d;
        @(posedge clk_i);
        #1;
        smp_valid_i = 1'b0;
        if (en_m) begin
            if (sb.size() < DEPTH) sb.push_back(d);
            else ovf_m = 1'b1;
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        wb.we_i  = 1'b0;
        wb.adr_i = '0;
        wb.dat_i = '0;
        wb.sel_i = '0;

        // Reset state
        #12;
        chk("rst_ack", {31'b0, wb.ack_o}, 32'd0);
        chk("rst_err", {31'b0, wb.err_o}, 32'd0);
        chk("rst_irq", {31'b0, irq_o}, 32'd0);
        chk("rst_dat", wb.dat_o, 32'd0);
        chk("rst_rty", {31'b0, wb.rty_o}, 32'd0);
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        rd_reg(REG_STATUS, status_exp(), "status_reset");
        rd_reg(REG_CTRL, 32'h0, "ctrl_reset");
        rd_reg(REG_THRESH, 32'h0, "thresh_reset");

        // Basic push and pop
        wr_reg(REG_CTRL, 32'h1, 4'h1, "wr_en");
        en_m = 1'b1;
        push(16'h0011);
        push(16'h0022);
        push(16'h0033);
        rd_reg(REG_STATUS, status_exp(), "status_lvl3");
        rd_pop("pop_11", 1'b1);
        rd_pop("pop_22", 1'b1);
        rd_pop("pop_33", 1'b1);

        // Overflow and error on empty
        for (int i = 0; i < 17; i++) push(16'h0100 + 16'(i));
        rd_reg(REG_STATUS, status_exp(), "status_full_ovf");
        chk("irq_thresh0", {31'b0, irq_o}, 32'd0);
        for (int i = 0; i < 16; i++) rd_pop("pop_ovf_seq", 1'b0);
        xfer({REG_DATA, 2'b00}, 1'b0, 32'h0, 4'hf, 1'b0, 16'h0, 1'b0);
        chk("empty_rd_err", {31'b0, terr}, 32'd1);
        chk("empty_rd_noack", {31'b0, tack}, 32'd0);
        rd_reg(REG_STATUS, status_exp(), "status_after_drain");
        wr_reg(REG_STATUS, 32'h4, 4'b1110, "w1c_nolane");
        rd_reg(REG_STATUS, status_exp(), "status_ovf_kept");
        wr_reg(REG_STATUS, 32'h4, 4'b0001, "w1c");
        ovf_m = 1'b0;
        rd_reg(REG_STATUS, status_exp(), "status_ovf_clr");

        // Simultaneous pop and push while full
        for (int i = 0; i < 16; i++) push(16'h0200 + 16'(i));
        begin
            logic [15:0] e;
            e = sb.pop_front();
            sb.push_back(16'h0777);
            xfer({REG_DATA, 2'b00}, 1'b0, 32'h0, 4'hf, 1'b1, 16'h0777, 1'b0);
            chk("full_pushpop_ack", {31'b0, tack}, 32'd1);
            chk("full_pushpop_data", rdat, {16'h0, e});
        end
        rd_reg(REG_STATUS, status_exp(), "status_full_noovf");
        for (int i = 0; i < 16; i++) rd_pop("pop_after_pushpop", 1'b0);

        // Threshold interrupt
        wr_reg(REG_THRESH, 32'h4, 4'h1, "wr_thresh");
        wr_reg(REG_THRESH, 32'h9, 4'b0010, "wr_thresh_nolane");
        rd_reg(REG_THRESH, 32'h4, "thresh_val");
        push(16'h0041);
        push(16'h0042);
        push(16'h0043);
        push(16'h0044);
        chk("irq_pre", {31'b0, irq_o}, 32'd0);
        @(posedge clk_i);
        #1;
        chk("irq_rise", {31'b0, irq_o}, 32'd1);
        rd_pop("pop_irq", 1'b0);
        chk("irq_hold", {31'b0, irq_o}, 32'd1);
        @(posedge clk_i);
        #1;
        chk("irq_fall", {31'b0, irq_o}, 32'd0);
        for (int i = 0; i < 3; i++) rd_pop("pop_irq_drain", 1'b0);

        // Clear with simultaneous sample
        push(16'h00a1);
        push(16'h00a2);
        xfer({REG_CTRL, 2'b00}, 1'b1, 32'h3, 4'h1, 1'b1, 16'h00bb, 1'b0);
        chk("clr_ack", {31'b0, tack}, 32'd1);
        sb.delete();
        rd_reg(REG_STATUS, status_exp(), "status_cleared");
        rd_reg(REG_CTRL, 32'h1, "ctrl_after_clr");

        // Reset in the middle of a read
        for (int i = 0; i < 5; i++) push(16'h00c0 + 16'(i));
        @(posedge clk_i);
        #1;
        chk("irq_before_rst", {31'b0, irq_o}, 32'd1);
        @(negedge clk_i);
        wb.cyc_i = 1'b1;
        wb.stb_i = 1'b1;
        wb.we_i  = 1'b0;
        wb.adr_i = {REG_DATA, 2'b00};
        @(posedge clk_i);
        #1;
        chk("midrd_ack", {31'b0, wb.ack_o}, 32'd1);
        #2;
        rst_i = 1'b0;
        #1;
        chk("midrd_rst_ack", {31'b0, wb.ack_o}, 32'd0);
        chk("midrd_rst_dat", wb.dat_o, 32'd0);
        chk("midrd_rst_irq", {31'b0, irq_o}, 32'd0);
        wb.cyc_i = 1'b0;
        wb.stb_i = 1'b0;
        @(negedge clk_i);
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        sb.delete();
        en_m = 1'b0;
        ovf_m = 1'b0;
        rd_reg(REG_STATUS, status_exp(), "status_post_rst");
        rd_reg(REG_CTRL, 32'h0, "ctrl_post_rst");
        rd_reg(REG_THRESH, 32'h0, "thresh_post_rst");
        xfer({REG_DATA, 2'b00}, 1'b1, 32'h1234, 4'hf, 1'b0, 16'h0, 1'b0);
        chk("wr_data_err", {31'b0, terr}, 32'd1);
        chk("wr_data_noack", {31'b0, tack}, 32'd0);
        push(16'h0055);
        rd_reg(REG_STATUS, status_exp(), "status_disabled_push");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
